// File: rtl/voice_mixer.sv
// Voice mixer: applies a per-channel linear attack/release envelope to a
// time-multiplexed stream of voice samples, sums one frame, scales and
// saturates the sum, and offers one mixed sample per frame downstream.
module voice_mixer #(
  parameter  int WIDTH        = 18,
  parameter  int NUM_CHANNELS = 16,
  parameter  int ENV_BITS     = 8,
  parameter  int ATK_STEP     = 4,
  parameter  int REL_STEP     = 2,
  parameter  int OUT_SHIFT    = 4,
  localparam int CH_BITS      = $clog2(NUM_CHANNELS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  input  logic [CH_BITS-1:0]      in_ch_i,
  input  logic [WIDTH-1:0]        in_sample_i,
  input  logic                    in_last_i,
  input  logic [NUM_CHANNELS-1:0] gate_i,
  input  logic                    out_ready_i,
  output logic                    out_valid_o,
  output logic [WIDTH-1:0]        out_sample_o,
  output logic                    overrun_o,
  input  logic                    clr_overrun_i
);

  localparam int ACC_W  = WIDTH + CH_BITS + 1;
  localparam int PROD_W = WIDTH + ENV_BITS + 1;

  localparam logic [ENV_BITS:0] ENV_MAX_X = {1'b0, {ENV_BITS{1'b1}}};
  localparam logic [ENV_BITS:0] ATK_X     = (ENV_BITS+1)'(ATK_STEP);
  localparam logic [ENV_BITS:0] REL_X     = (ENV_BITS+1)'(REL_STEP);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic {EMPTY, FULL} outState_e;

  outState_e state_q, state_d;

  logic [ENV_BITS-1:0]     level_q [NUM_CHANNELS];
  logic [ENV_BITS-1:0]     level_d;
  logic [ENV_BITS-1:0]     curLevel;
  logic                    chInRange;
  logic [ENV_BITS:0]       levelUp;
  logic [ENV_BITS:0]       levelDn;

  logic signed [PROD_W-1:0] prod;
  logic signed [WIDTH-1:0]  scaled;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  frameSum;
  logic signed [ACC_W-1:0]  sumShift;
  logic [WIDTH-1:0]         res;

  logic                    frameEnd;
  logic                    loadOut;
  logic                    dropRes;
  logic [WIDTH-1:0]        out_sample_q;
  logic                    overrun_q;

  // Out-of-range channel indices contribute nothing and leave every envelope alone.
  assign chInRange = {1'b0, in_ch_i} < (CH_BITS+1)'(NUM_CHANNELS);
  assign curLevel  = chInRange ? level_q[in_ch_i] : '0;
  assign frameEnd  = in_valid_i && in_last_i;

  // Level is zero-extended so the multiply stays a signed product of the sample.
  assign prod     = PROD_W'($signed(in_sample_i)) * PROD_W'($signed({1'b0, curLevel}));
  assign scaled   = prod[WIDTH+ENV_BITS-1:ENV_BITS];
  assign frameSum = acc_q + ACC_W'(scaled);
  assign sumShift = frameSum >>> OUT_SHIFT;

  // Next envelope level for the addressed channel, clamped at both ends instead of wrapping.
  always_comb begin
    levelUp = {1'b0, curLevel} + ATK_X;
    levelDn = {1'b0, curLevel} - REL_X;
    level_d = curLevel;
    if (gate_i[in_ch_i]) begin
      level_d = (levelUp > ENV_MAX_X) ? ENV_MAX_X[ENV_BITS-1:0] : levelUp[ENV_BITS-1:0];
    end else begin
      level_d = ({1'b0, curLevel} < REL_X) ? '0 : levelDn[ENV_BITS-1:0];
    end
  end

  // Envelope levels advance once per consumed sample of their own channel.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        level_q[i] <= '0;
      end
    end else if (in_valid_i && chInRange) begin
      level_q[in_ch_i] <= level_d;
    end
  end

  // Frame accumulator restarts from zero on the cycle that closes a frame.
  always_comb begin
    acc_d = acc_q;
    if (in_valid_i) begin
      acc_d = in_last_i ? '0 : frameSum;
    end
  end

  // Accumulator register; a reset mid-frame throws away the partial sum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Saturate the scaled frame sum into the output sample range.
  always_comb begin
    res = sumShift[WIDTH-1:0];
    if (sumShift > SAT_MAX) begin
      res = SAT_MAX[WIDTH-1:0];
    end else if (sumShift < SAT_MIN) begin
      res = SAT_MIN[WIDTH-1:0];
    end
  end

  // Output holding register state: EMPTY or FULL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A new result keeps the register full; a handshake without one empties it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (frameEnd) state_d = FULL;
      FULL:    if (out_ready_i && !frameEnd) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // A result loads when the slot is free or being drained this cycle, otherwise it is dropped.
  always_comb begin
    out_valid_o = (state_q == FULL);
    loadOut     = frameEnd && ((state_q == EMPTY) || out_ready_i);
    dropRes     = frameEnd && (state_q == FULL) && !out_ready_i;
  end

  // Output sample and sticky overrun flag; a drop beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_sample_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (loadOut) begin
        out_sample_q <= res;
      end
      if (dropRes) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun_i) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign out_sample_o = out_sample_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Bench for voice_mixer: two instances (output shift 4 and 0) share one input
// stream and are compared every cycle against a behavioural frame model.
module tb_voice_mixer;

  localparam int NCH  = 16;
  localparam longint SMAX = 131071;
  localparam longint SMIN = -131072;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        inValid = 1'b0;
  logic [3:0]  inCh = '0;
  logic [17:0] inSample = '0;
  logic        inLast = 1'b0;
  logic [15:0] gate = '0;
  logic        outReady = 1'b1;
  logic        clrOverrun = 1'b0;

  logic        outValidA, outValidB;
  logic [17:0] outSampleA, outSampleB;
  logic        overrunA, overrunB;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: envelope per channel, running frame sum, one output slot per instance.
  int     mLevel [NCH];
  longint mAcc = 0;
  bit     mValid [2];
  longint mSample [2];
  bit     mOverrun [2];

  voice_mixer #(.OUT_SHIFT(4)) dutA (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid), .in_ch_i(inCh),
    .in_sample_i(inSample), .in_last_i(inLast), .gate_i(gate),
    .out_ready_i(outReady), .out_valid_o(outValidA), .out_sample_o(outSampleA),
    .overrun_o(overrunA), .clr_overrun_i(clrOverrun)
  );

  voice_mixer #(.OUT_SHIFT(0)) dutB (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid), .in_ch_i(inCh),
    .in_sample_i(inSample), .in_last_i(inLast), .gate_i(gate),
    .out_ready_i(outReady), .out_valid_o(outValidB), .out_sample_o(outSampleB),
    .overrun_o(overrunB), .clr_overrun_i(clrOverrun)
  );

  always #5 clk = ~clk;

  function automatic int shiftOf(input int d);
    return (d == 0) ? 4 : 0;
  endfunction

  // One consumed beat of the model: scale with the old level, then move the level.
  task automatic modelStep();
    longint scaled, total, r;
    longint res [2];
    int lvl;
    bit frameEnd;
    bit drop;
    frameEnd = 1'b0;
    res[0] = 0;
    res[1] = 0;
    if (inValid) begin
      lvl = mLevel[inCh];
      scaled = (longint'($signed(inSample)) * lvl) >>> 8;
      if (gate[inCh]) mLevel[inCh] = (lvl + 4 > 255) ? 255 : lvl + 4;
      else            mLevel[inCh] = (lvl - 2 < 0) ? 0 : lvl - 2;
      if (inLast) begin
        frameEnd = 1'b1;
        total = mAcc + scaled;
        mAcc = 0;
        for (int d = 0; d < 2; d++) begin
          r = total >>> shiftOf(d);
          if (r > SMAX) r = SMAX;
          if (r < SMIN) r = SMIN;
          res[d] = r;
        end
      end else begin
        mAcc = mAcc + scaled;
      end
    end
    for (int d = 0; d < 2; d++) begin
      drop = frameEnd && mValid[d] && !outReady;
      if (frameEnd && (!mValid[d] || outReady)) begin
        mSample[d] = res[d];
        mValid[d]  = 1'b1;
      end else if (mValid[d] && outReady) begin
        mValid[d] = 1'b0;
      end
      if (drop) mOverrun[d] = 1'b1;
      else if (clrOverrun) mOverrun[d] = 1'b0;
    end
  endtask

  // Model follows the clock and the asynchronous reset exactly like the outputs should.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < NCH; i++) mLevel[i] = 0;
      mAcc = 0;
      for (int d = 0; d < 2; d++) begin
        mValid[d] = 1'b0;
        mSample[d] = 0;
        mOverrun[d] = 1'b0;
      end
    end else begin
      modelStep();
    end
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Pins both the DUT and the model to a hand-computed value.
  task automatic checkLit(input string name, input longint dutVal, input longint modelVal, input longint lit);
    checkOutput({name, "_dut"}, dutVal, lit);
    checkOutput({name, "_model"}, modelVal, lit);
  endtask

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rstN) begin
      checkOutput("validA", longint'(outValidA), longint'(mValid[0]));
      checkOutput("sampleA", longint'($signed(outSampleA)), mSample[0]);
      checkOutput("overrunA", longint'(overrunA), longint'(mOverrun[0]));
      checkOutput("validB", longint'(outValidB), longint'(mValid[1]));
      checkOutput("sampleB", longint'($signed(outSampleB)), mSample[1]);
      checkOutput("overrunB", longint'(overrunB), longint'(mOverrun[1]));
    end
  end

  // Drive one full frame (channels 0..15 in order), then one idle cycle.
  task automatic applyStimulus(input int s0, input int sRest, input bit readyOnLast, input bit clrOnLast);
    for (int ch = 0; ch < NCH; ch++) begin
      @(negedge clk);
      inValid  = 1'b1;
      inCh     = 4'(ch);
      inSample = 18'((ch == 0) ? s0 : sRest);
      inLast   = (ch == NCH - 1);
      if (ch == NCH - 1) begin
        if (readyOnLast) outReady = 1'b1;
        if (clrOnLast) clrOverrun = 1'b1;
      end
    end
    @(negedge clk);
    inValid    = 1'b0;
    inLast     = 1'b0;
    clrOverrun = 1'b0;
  endtask

  // Random frame: shuffled channels, random gaps, random backpressure and clears.
  task automatic randomFrame(input bit withLast);
    for (int b = 0; b < NCH; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        inValid    = 1'b0;
        inLast     = 1'b0;
        outReady   = 1'($urandom_range(0, 1));
        clrOverrun = ($urandom_range(0, 7) == 0);
      end
      @(negedge clk);
      inValid    = 1'b1;
      inCh       = 4'($urandom_range(0, NCH - 1));
      inSample   = 18'($urandom);
      inLast     = withLast && (b == NCH - 1);
      outReady   = 1'($urandom_range(0, 1));
      clrOverrun = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    bit prevSkip;
    bit skip;
    #1 rstN = 1'b0;
    #3;
    checkLit("rst_valid", longint'(outValidA), longint'(mValid[0]), 0);
    checkLit("rst_sample", longint'($signed(outSampleA)), mSample[0], 0);
    checkLit("rst_overrun", longint'(overrunB), longint'(mOverrun[1]), 0);
    repeat (3) @(negedge clk);
    #2 rstN = 1'b1;

    // Attack ramp on channel 0 only.
    gate = 16'h0001;
    for (int k = 1; k <= 70; k++) begin
      applyStimulus(1000, 0, 1'b0, 1'b0);
      if (k == 1) begin
        checkLit("ramp_f1", longint'($signed(outSampleA)), mSample[0], 0);
        checkLit("valid_rise", longint'(outValidA), longint'(mValid[0]), 1);
      end
      if (k == 17) begin
        checkLit("ramp_f17_A", longint'($signed(outSampleA)), mSample[0], 15);
        checkLit("ramp_f17_B", longint'($signed(outSampleB)), mSample[1], 250);
      end
      if (k >= 65) checkLit("ramp_full", longint'($signed(outSampleA)), mSample[0], 62);
    end

    // All channels up to full level.
    gate = 16'hFFFF;
    repeat (64) applyStimulus(1000, 1000, 1'b0, 1'b0);
    applyStimulus(1000, 1000, 1'b0, 1'b0);
    checkLit("all_A", longint'($signed(outSampleA)), mSample[0], 996);
    checkLit("all_B", longint'($signed(outSampleB)), mSample[1], 15936);

    // Saturation at both rails.
    applyStimulus(131071, 131071, 1'b0, 1'b0);
    checkLit("satpos_A", longint'($signed(outSampleA)), mSample[0], 130559);
    checkLit("satpos_B", longint'($signed(outSampleB)), mSample[1], 131071);
    applyStimulus(-131072, -131072, 1'b0, 1'b0);
    checkLit("satneg_A", longint'($signed(outSampleA)), mSample[0], -130560);
    checkLit("satneg_B", longint'($signed(outSampleB)), mSample[1], -131072);

    // Release of channel 0 down to silence.
    gate = 16'h0000;
    for (int r = 1; r <= 130; r++) begin
      applyStimulus(1000, 0, 1'b0, 1'b0);
      if (r == 1) checkLit("rel_f1", longint'($signed(outSampleA)), mSample[0], 62);
      if (r == 2) checkLit("rel_f2", longint'($signed(outSampleA)), mSample[0], 61);
      if (r == 130) begin
        checkLit("rel_end_A", longint'($signed(outSampleA)), mSample[0], 0);
        checkLit("rel_end_B", longint'($signed(outSampleB)), mSample[1], 0);
      end
    end

    // Backpressure, drop, clear, handshake on frame end, set beats clear.
    gate = 16'hFFFF;
    repeat (3) applyStimulus(1000, 1000, 1'b0, 1'b0);
    outReady = 1'b0;
    applyStimulus(1000, 1000, 1'b0, 1'b0);
    applyStimulus(2000, 2000, 1'b0, 1'b0);
    checkLit("bp_overrun", longint'(overrunA), longint'(mOverrun[0]), 1);
    checkLit("bp_valid", longint'(outValidA), longint'(mValid[0]), 1);
    clrOverrun = 1'b1;
    @(negedge clk);
    clrOverrun = 1'b0;
    checkLit("clr_overrun", longint'(overrunA), longint'(mOverrun[0]), 0);
    applyStimulus(3000, 3000, 1'b1, 1'b0);
    checkLit("hs_valid", longint'(outValidA), longint'(mValid[0]), 1);
    checkLit("hs_overrun", longint'(overrunA), longint'(mOverrun[0]), 0);
    outReady = 1'b0;
    applyStimulus(1000, 1000, 1'b0, 1'b1);
    checkLit("set_wins", longint'(overrunB), longint'(mOverrun[1]), 1);

    // Reset after seven samples of a frame.
    for (int ch = 0; ch < 7; ch++) begin
      @(negedge clk);
      inValid  = 1'b1;
      inCh     = 4'(ch);
      inSample = 18'(1000);
      inLast   = 1'b0;
    end
    @(negedge clk);
    inValid = 1'b0;
    #2 rstN = 1'b0;
    #1;
    checkLit("mid_rst_valid", longint'(outValidA), longint'(mValid[0]), 0);
    checkLit("mid_rst_sample", longint'($signed(outSampleB)), mSample[1], 0);
    checkLit("mid_rst_overrun", longint'(overrunA), longint'(mOverrun[0]), 0);
    @(negedge clk);
    #2 rstN = 1'b1;
    outReady = 1'b1;
    applyStimulus(1000, 1000, 1'b0, 1'b0);
    checkLit("post_rst_f1_A", longint'($signed(outSampleA)), mSample[0], 0);
    checkLit("post_rst_f1_B", longint'($signed(outSampleB)), mSample[1], 0);
    applyStimulus(1000, 1000, 1'b0, 1'b0);
    checkLit("post_rst_f2_A", longint'($signed(outSampleA)), mSample[0], 15);
    checkLit("post_rst_f2_B", longint'($signed(outSampleB)), mSample[1], 240);

    // Randomised traffic, occasionally with a missing frame delimiter.
    prevSkip = 1'b0;
    for (int f = 0; f < 80; f++) begin
      gate = 16'($urandom);
      skip = !prevSkip && ($urandom_range(0, 7) == 0);
      randomFrame(!skip);
      prevSkip = skip;
    end
    randomFrame(1'b1);
    @(negedge clk);
    inValid    = 1'b0;
    inLast     = 1'b0;
    clrOverrun = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
